// File: rtl/game_pkg.sv
// Shared screen/sprite geometry, colour constants and blit FSM state type.
// Pure declarations: no latency, no flow control.
package game_pkg;
  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int SPRITE_W  = 40;
  localparam int SPRITE_H  = 40;
  localparam int COLOUR_W  = 3;
  localparam int SCREEN_AW = 15;
  localparam int SPRITE_AW = 11;
  localparam int COL_W     = 6;
  localparam int ROW_W     = 6;
  localparam int SPRITE_PIX = SPRITE_W * SPRITE_H;
  localparam logic [COLOUR_W-1:0] TRANSPARENT = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } blit_state_t;
endpackage

// File: rtl/sprite_xy_counter.sv
// Col/row/linear sprite address counter; registered outputs, advances one pixel per enabled cycle.
// Holds on the last pixel until cleared; clear has priority over enable.
module sprite_xy_counter
  import game_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clear,
  input  logic                 enable,
  output logic [COL_W-1:0]     col,
  output logic [ROW_W-1:0]     row,
  output logic [SPRITE_AW-1:0] addr,
  output logic                 last
);
  assign last = (addr == SPRITE_AW'(SPRITE_PIX - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (clear) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (enable && !last) begin
      addr <= addr + SPRITE_AW'(1);
      if (col == COL_W'(SPRITE_W - 1)) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end
endmodule

// File: rtl/sprite_blit_engine.sv
// Blits a 40x40 ROM sprite to the framebuffer: plot for address k appears 2 cycles after k is issued.
// No backpressure: runs one pixel per cycle; start is ignored while busy.
module sprite_blit_engine
  import game_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [7:0]           origin_x,
  input  logic [6:0]           origin_y,
  output logic                 busy,
  output logic                 done,
  output logic [SPRITE_AW-1:0] sprite_addr,
  input  logic [COLOUR_W-1:0]  sprite_data,
  output logic [7:0]           vga_x,
  output logic [6:0]           vga_y,
  output logic [COLOUR_W-1:0]  vga_colour,
  output logic                 vga_plot
);
  blit_state_t state, state_nxt;
  logic        drain_cnt;
  logic        accept;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic        last;
  logic [7:0]  org_x;
  logic [6:0]  org_y;
  logic        p_vld;
  logic [8:0]  p_x;
  logic [7:0]  p_y;
  logic        plot_nxt;

  sprite_xy_counter u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clear  (accept),
    .enable (state == S_RUN),
    .col    (col),
    .row    (row),
    .addr   (sprite_addr),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN:   if (last) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt) state_nxt = S_DONE;
      S_DONE: begin
        accept    = start;
        state_nxt = start ? S_RUN : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  // Screen coordinates carry one extra bit so an overflowing sum clips instead of wrapping on-screen.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      org_x <= '0;
      org_y <= '0;
      p_vld <= 1'b0;
      p_x   <= '0;
      p_y   <= '0;
    end else begin
      if (accept) begin
        org_x <= origin_x;
        org_y <= origin_y;
      end
      p_vld <= (state == S_RUN);
      p_x   <= {1'b0, org_x} + 9'(col);
      p_y   <= {1'b0, org_y} + 8'(row);
    end
  end

  assign plot_nxt = p_vld && (sprite_data != TRANSPARENT) &&
                    (p_x < 9'(SCREEN_W)) && (p_y < 8'(SCREEN_H));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      vga_plot <= plot_nxt;
      if (plot_nxt) begin
        vga_x      <= p_x[7:0];
        vga_y      <= p_y[6:0];
        vga_colour <= sprite_data;
      end
    end
  end
endmodule

// File: tb/tb_sprite_blit_engine.sv
// Randomised bench for sprite_blit_engine: a cycle-indexed reference model of the blit
// timeline is compared every cycle, plus literal expectations for the directed scenarios.
module tb_sprite_blit_engine;
  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [7:0]  origin_x;
  logic [6:0]  origin_y;
  logic        busy, done, vga_plot;
  logic [10:0] sprite_addr;
  logic [2:0]  sprite_data = 3'b000;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;

  always #5 clk = ~clk;

  sprite_blit_engine dut (
    .clk(clk), .resetn(resetn), .start(start),
    .origin_x(origin_x), .origin_y(origin_y),
    .busy(busy), .done(done), .sprite_addr(sprite_addr), .sprite_data(sprite_data),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ROM contents: 0 = constant 3'b010, 1 = transparent on even addresses, 2 = random table
  int         rom_mode = 0;
  logic [2:0] rom_mem [1600];

  function automatic logic [2:0] rom_val(input int k);
    logic [2:0] v;
    v = 3'b000;
    if (rom_mode == 0) v = 3'b010;
    else if (rom_mode == 1) v = (k % 2 == 0) ? 3'b101 : (3'(k) ^ 3'b001);
    else if (k >= 0 && k < 1600) v = rom_mem[k];
    return v;
  endfunction

  always @(posedge clk) sprite_data <= rom_val(int'(sprite_addr));

  // Reference model: n is the spec cycle number of the current blit (0 = none in flight)
  int edges = 0;
  int n = 0;
  int mox = 0, moy = 0;
  int e_addr = 0, e_x = 0, e_y = 0, e_c = 0;
  bit e_plot = 1'b0;

  always @(posedge clk) begin
    int k, col, row, c;
    edges++;
    if (!resetn) begin
      n = 0; e_addr = 0; e_x = 0; e_y = 0; e_c = 0;
    end else if (start && !(n >= 1 && n <= 1602)) begin
      n = 1; mox = int'(origin_x); moy = int'(origin_y);
    end else if (n >= 1603) begin
      n = 0;
    end else if (n != 0) begin
      n++;
    end
    e_plot = 1'b0;
    if (n >= 1 && n <= 1600) e_addr = n - 1;
    if (n >= 3 && n <= 1602) begin
      k = n - 3; col = k % 40; row = k / 40; c = int'(rom_val(k));
      if (c != 5 && mox + col < 160 && moy + row < 120) begin
        e_plot = 1'b1; e_x = mox + col; e_y = moy + row; e_c = c;
      end
    end
  end

  // Per-blit statistics used by the literal expectations
  int s_edge = 0;
  int plots, dones, done_rel, first_rel, last_rel;
  int first_x, first_y, last_x, last_y, bad_col, clip_bad, lo_x, lo_y;
  bit chk_en = 1'b0;

  task automatic clear_stats();
    plots = 0; dones = 0; done_rel = 0; first_rel = 0; last_rel = 0;
    first_x = 0; first_y = 0; last_x = 0; last_y = 0; bad_col = 0; clip_bad = 0;
    lo_x = 0; lo_y = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, (n >= 1 && n <= 1602));
      check("done", done, (n == 1603));
      check("sprite_addr", sprite_addr, e_addr);
      check("vga_plot", vga_plot, e_plot);
      check("vga_x", vga_x, e_x);
      check("vga_y", vga_y, e_y);
      check("vga_colour", vga_colour, e_c);
      if (vga_plot === 1'b1) begin
        plots++;
        if (plots == 1) begin
          first_rel = edges - s_edge + 1; first_x = vga_x; first_y = vga_y;
        end
        last_rel = edges - s_edge + 1; last_x = vga_x; last_y = vga_y;
        if (vga_colour == 3'b101) bad_col++;
        if (vga_x < lo_x || vga_x > 159 || vga_y < lo_y || vga_y > 119) clip_bad++;
      end
      if (done === 1'b1) begin
        dones++; done_rel = edges - s_edge + 1;
      end
    end
  end

  task automatic start_blit(input logic [7:0] ox, input logic [6:0] oy);
    @(negedge clk);
    start = 1'b1; origin_x = ox; origin_y = oy;
    @(posedge clk);
    #1 s_edge = edges;
    @(negedge clk);
    start = 1'b0; origin_x = 8'($urandom); origin_y = 7'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (dones == 0 && i < budget) begin
      @(negedge clk); #1; i++;
    end
    if (dones == 0) check("done_timeout", 0, 1);
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic wait_rel(input int rel);
    int i;
    i = 0;
    while ((edges - s_edge + 1) != rel && i < 3000) begin
      @(negedge clk); i++;
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b1; origin_x = 8'd0; origin_y = 7'd0;
    clear_stats();
    chk_en = 1'b1;

    // 1: reset held with start asserted
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_addr", sprite_addr, 0);
    check("rst_x", vga_x, 0);
    check("rst_plots", plots, 0);
    @(negedge clk);
    resetn = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);

    // 2: full draw at (10,20)
    rom_mode = 0; clear_stats();
    start_blit(8'd10, 7'd20);
    wait_done(2000);
    check("full_plots", plots, 1600);
    check("full_first_cyc", first_rel, 3);
    check("full_first_x", first_x, 10);
    check("full_first_y", first_y, 20);
    check("full_last_cyc", last_rel, 1602);
    check("full_last_x", last_x, 49);
    check("full_last_y", last_y, 59);
    check("full_done_cyc", done_rel, 1603);
    check("full_dones", dones, 1);

    // 3: transparency
    rom_mode = 1; clear_stats();
    start_blit(8'd30, 7'd5);
    wait_done(2000);
    check("transp_plots", plots, 800);
    check("transp_colour", bad_col, 0);

    // 4: clipping at bottom-right corner
    rom_mode = 0; clear_stats(); lo_x = 140; lo_y = 100;
    start_blit(8'd140, 7'd100);
    wait_done(2000);
    check("clip_plots", plots, 400);
    check("clip_range", clip_bad, 0);
    check("clip_done_cyc", done_rel, 1603);

    // 5: start while busy is ignored
    clear_stats();
    start_blit(8'd10, 7'd20);
    wait_rel(700);
    start = 1'b1; origin_x = 8'd0; origin_y = 7'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000);
    check("busy_start_dones", dones, 1);
    check("busy_start_plots", plots, 1600);
    check("busy_start_last_x", last_x, 49);
    check("busy_start_last_y", last_y, 59);

    // 6: reset mid-blit, then a fresh blit
    clear_stats();
    start_blit(8'd50, 7'd60);
    wait_rel(500);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_plot", vga_plot, 0);
    check("midrst_busy", busy, 0);
    resetn = 1'b1;
    repeat (1300) @(negedge clk);
    #1;
    check("midrst_no_done", dones, 0);
    clear_stats();
    start_blit(8'd0, 7'd0);
    #1;
    check("restart_addr", sprite_addr, 0);
    wait_done(2000);
    check("restart_dones", dones, 1);
    check("restart_done_cyc", done_rel, 1603);

    // 7: random origins (including wrapping sums) and random ROM contents
    rom_mode = 2;
    for (int t = 0; t < 4; t++) begin
      for (int a = 0; a < 1600; a++) rom_mem[a] = 3'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      clear_stats();
      start_blit(8'($urandom), 7'($urandom));
      wait_done(2000);
      check("rand_dones", dones, 1);
    end

    // 8: start held high is accepted again in the done cycle
    clear_stats();
    @(negedge clk);
    start = 1'b1; origin_x = 8'($urandom_range(0, 159)); origin_y = 7'($urandom_range(0, 119));
    begin
      int i;
      i = 0;
      while (dones < 2 && i < 4000) begin
        @(negedge clk); #1; i++;
      end
      if (dones < 2) check("b2b_timeout", dones, 2);
    end
    start = 1'b0;
    wait_done(2000);
    check("b2b_dones", dones, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
